// File: rtl/line_buffer_3row_pkg.sv
// Shared types for the 3-row line buffer feeding the Sobel window stage.
// Contents: pixel width, pixel type and the FSM state encoding.
package linebuf_pkg;

    localparam int PIX_W = 12;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DONE
    } lb_state_t;

endpackage

// File: rtl/line_buffer_3row_if.sv
// Pixel stream in / three-row column stream out for the line buffer.
// slave: the line buffer (takes pixels, drives rows); master: source/sink.
interface line_buffer_3row_if;
    import linebuf_pkg::*;

    pixel_t pix_in;
    logic   pix_valid;
    logic   frame_start;
    pixel_t row0_pixel;
    pixel_t row1_pixel;
    pixel_t row2_pixel;
    logic   out_valid;
    logic   row2_pixel_edge;
    logic   frame_done;

    modport slave (
        input  pix_in,
        input  pix_valid,
        input  frame_start,
        output row0_pixel,
        output row1_pixel,
        output row2_pixel,
        output out_valid,
        output row2_pixel_edge,
        output frame_done
    );

    modport master (
        output pix_in,
        output pix_valid,
        output frame_start,
        input  row0_pixel,
        input  row1_pixel,
        input  row2_pixel,
        input  out_valid,
        input  row2_pixel_edge,
        input  frame_done
    );

endinterface

// File: rtl/line_buffer_3row_row_buffer.sv
// One line of pixel storage: async read and sync write at the same address.
// Ports: clk, we, addr, wdata, rdata (rdata shows the pre-write contents).
module row_buffer
    import linebuf_pkg::*;
#(
    parameter int DEPTH = 640,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pixel_t        wdata,
    output pixel_t        rdata
);

    pixel_t mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/line_buffer_3row.sv
// Raster pixel stream to vertically aligned 3-pixel columns (lines r-2..r).
// Ports: clk, rst (async, active-high), bus (line_buffer_3row_if.slave).
// Build option: LINEBUF_ZERO_PAD_EN also emits rows 0-1 with zero padding.
module line_buffer_3row
    import linebuf_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input logic               clk,
    input logic               rst,
    line_buffer_3row_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    lb_state_t     state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [CW-1:0] eff_col;
    logic [RW-1:0] eff_row;
    logic          accept;
    logic          emit;
    logic          col_last;
    logic          row_last;
    pixel_t        la_q;
    pixel_t        lb_q;
    pixel_t        row0_d;
    pixel_t        row1_d;

    pixel_t        row0_q;
    pixel_t        row1_q;
    pixel_t        row2_q;
    logic          valid_q;
    logic          edge_q;
    logic          done_q;

    // A qualified frame_start overrides the counters as (0,0)
    // in the same cycle, from any state.
    assign accept  = bus.pix_valid
                   & (bus.frame_start
                   | (state == FILL)
                   | (state == STREAM));
    assign eff_col = bus.frame_start ? '0 : col;
    assign eff_row = bus.frame_start ? '0 : row;
    assign col_last = (eff_col == COL_LAST);
    assign row_last = (eff_row == ROW_LAST);

    // LA holds line r-1; LB takes LA's old pixel, so it holds r-2.
    row_buffer #(.DEPTH(WIDTH)) u_la (
        .clk   (clk),
        .we    (accept),
        .addr  (eff_col),
        .wdata (bus.pix_in),
        .rdata (la_q)
    );

    row_buffer #(.DEPTH(WIDTH)) u_lb (
        .clk   (clk),
        .we    (accept),
        .addr  (eff_col),
        .wdata (la_q),
        .rdata (lb_q)
    );

`ifdef LINEBUF_ZERO_PAD_EN
    // Lines above the frame top read as zero.
    assign emit   = accept;
    assign row0_d = (eff_row < ROW_TWO) ? '0 : lb_q;
    assign row1_d = (eff_row == '0) ? '0 : la_q;
`else
    assign emit   = accept & (eff_row >= ROW_TWO);
    assign row0_d = lb_q;
    assign row1_d = la_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            col     <= '0;
            row     <= '0;
            row0_q  <= '0;
            row1_q  <= '0;
            row2_q  <= '0;
            valid_q <= 1'b0;
            edge_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= emit;
            done_q  <= (state == DONE);
            if (emit) begin
                row0_q <= row0_d;
                row1_q <= row1_d;
                row2_q <= bus.pix_in;
                edge_q <= (eff_col < COL_TWO);
            end
            if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : eff_row + RW'(1);
                end else begin
                    col <= eff_col + CW'(1);
                    row <= eff_row;
                end
                unique case (1'b1)
                    bus.frame_start:
                        state <= FILL;
                    col_last && row_last:
                        state <= DONE;
                    col_last && (eff_row == ROW_ONE):
                        state <= STREAM;
                    default:
                        state <= state;
                endcase
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end

    assign bus.row0_pixel      = row0_q;
    assign bus.row1_pixel      = row1_q;
    assign bus.row2_pixel      = row2_q;
    assign bus.out_valid       = valid_q;
    assign bus.row2_pixel_edge = edge_q;
    assign bus.frame_done      = done_q;

endmodule

// File: doc/line_buffer_3row.md
# line_buffer_3row

Upstream window-feed stage for the 3x3 Sobel convolution stage. Accepts a raster-order 12-bit grayscale pixel stream, stores the two most recent complete lines, and emits three vertically aligned pixels per input pixel. Its outputs connect directly to the convolution stage's `row0_pixel`/`row1_pixel`/`row2_pixel`/`valid`/`row2_pixel_edge` inputs.

## Interface
- `WIDTH`, 640, pixels per line (≥3)
- `HEIGHT`, 480, lines per frame (≥3)
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `pix_in`  in  12  input pixel
- `pix_valid`  in  1  `pix_in` valid this cycle; gaps allowed
- `frame_start`  in  1  qualified by `pix_valid`; marks pixel (row 0, col 0)
- `row0_pixel`  out  12  pixel from line r-2, same column
- `row1_pixel`  out  12  pixel from line r-1, same column
- `row2_pixel`  out  12  pixel from line r (current input)
- `out_valid`  out  1  row outputs valid
- `row2_pixel_edge`  out  1  output column is 0 or 1 (3-column window straddles line start)
- `frame_done`  out  1  one-cycle pulse after last pixel of frame is output

## Operation
- FSM states: IDLE, FILL, STREAM, DONE.
- IDLE: pixels without `frame_start` are dropped. `pix_valid && frame_start` → col=0, row=0, state FILL; the pixel is accepted.
- Counters: `col` 0..WIDTH-1 and `row` 0..HEIGHT-1 advance only on accepted pixels. At col=WIDTH-1, col wraps to 0 and row increments.
- Storage: two WIDTH×12 line buffers. LA holds line r-1, LB holds line r-2.
- Per accepted pixel at column c: read LA[c] and LB[c], then write LB[c]←LA[c] and LA[c]←pix_in in the same cycle (read-before-write).
- FILL covers rows 0–1; `out_valid` stays 0. When row becomes 2 → STREAM.
- STREAM: every accepted pixel produces `out_valid`=1 with row0=LB[c], row1=LA[c], row2=pix_in.
- The last pixel (row HEIGHT-1, col WIDTH-1) → DONE. DONE asserts `frame_done` for one cycle, then → IDLE.
- `frame_start` with `pix_valid` in any state restarts the frame: counters are set to (0,0), state FILL, and the pixel is accepted as row 0 col 0. Line buffer contents are not cleared. An in-flight output from the previous cycle still completes.
- `frame_start` without `pix_valid` is ignored.
- `row2_pixel_edge` = (c < 2), registered alongside the pixels.

## Timing
- Latency: 1 cycle from an accepted pixel to its registered outputs.
- Throughput: 1 pixel/cycle sustained. Input gaps map one-to-one onto `out_valid` gaps.
- No backpressure; the downstream stage must accept every valid cycle.
- Reset values: all outputs 0, state IDLE, col=row=0. Line buffer RAM is not reset.
- `rst` asserted mid-frame: outputs go to 0 immediately. After release, the block waits for a new `frame_start`.
- `frame_done` is asserted in the cycle after the final `out_valid`.

## Configuration
- `LINEBUF_ZERO_PAD_EN`
  - Defined: rows 0 and 1 are also output with `out_valid`=1, and missing lines read as 0. Row 0 outputs row0=row1=0. Row 1 outputs row0=0 and row1=LA[c]. The output count per frame is WIDTH×HEIGHT.
  - Undefined: rows 0–1 produce no output. The output count per frame is WIDTH×(HEIGHT-2).

## Structure
- `linebuf_pkg` contains:
  - `PIX_W`=12
  - `typedef logic [PIX_W-1:0] pixel_t`
  - the FSM state enum `lb_state_t`
- Sub-module `row_buffer`: WIDTH-deep pixel_t memory, one combinational read port and one synchronous write port at the same address, with read-before-write. It is instantiated twice (LA, LB).
- Top level holds the FSM, counters, output registers and pad muxing.

## Test plan
- WIDTH=4, HEIGHT=4, pixels 1..16 streamed contiguously after reset, macro undefined → 8 outputs. First output is (row0,row1,row2)=(1,5,9) with edge=1. Fourth output is (4,8,12) with edge=0. Last output is (8,12,16). `frame_done` pulses once, one cycle after the last `out_valid`.
- Same stream with `pix_valid` toggled 1/0 each cycle → identical output values, `out_valid` alternating, latency still 1 cycle.
- Same stream with macro defined → 16 outputs. First is (0,0,1). Fifth is (0,1,5). Ninth is (1,5,9).
- `frame_start` reasserted at pixel 7 with value 100 → counters restart. No `out_valid` for the next 8 accepted pixels, and no `frame_done` for the aborted frame.
- `rst` pulsed during STREAM → all outputs 0 that cycle. Pixels without `frame_start` afterward produce no output.
- Pixels presented in IDLE without `frame_start` (values 50..53), then a normal frame → the first frame output matches the scenario-1 results exactly.
